// File: rtl/mix_columns_all.sv
// ---------------------------------------------------------------------------
// mix_columns_all
//   Registered AES MixColumns / InvMixColumns over a full 128-bit state.
//   All four columns are transformed in parallel by identical combinational
//   logic, and the result is captured in a single output register.
//   Latency is one clock and throughput is one state per clock.
//
// Ports
//   clk      in   1    rising-edge clock
//   reset    in   1    asynchronous, active-high reset; clears mixOut to 0
//   mixIn    in   128  input state, column-major (mixIn[127:120] = s(0,0))
//   inverse  in   1    0 = MixColumns, 1 = InvMixColumns, sampled with mixIn
//   mixOut   out  128  transformed state, registered, same byte layout
// ---------------------------------------------------------------------------
module mix_columns_all (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] mixIn,
  input  logic         inverse,
  output logic [127:0] mixOut
);

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xt(x) ^ x;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    return x ^ xt(xt(xt(x)));
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] x);
    return mul9(x) ^ xt(x);
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] x);
    return mul9(x) ^ xt(xt(x));
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] x);
    return xt(x) ^ xt(xt(x)) ^ xt(xt(xt(x)));
  endfunction

  // Transform one 32-bit column; the MSB byte is row 0.
  function automatic logic [31:0] mix_col(input logic [31:0] col,
                                          input logic        inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = col;
    if (!inv) begin
      b0 = xt(a0) ^ mul3(a1) ^ a2       ^ a3;
      b1 = a0     ^ xt(a1)   ^ mul3(a2) ^ a3;
      b2 = a0     ^ a1       ^ xt(a2)   ^ mul3(a3);
      b3 = mul3(a0) ^ a1     ^ a2       ^ xt(a3);
    end else begin
      b0 = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
      b1 = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
      b2 = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
      b3 = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
    end
    return {b0, b1, b2, b3};
  endfunction

  logic [127:0] mix_d;
  logic [127:0] mix_q;

  // NOTE: every bit of mix_d is assigned on every pass (default first, then
  // the per-column loop), so no latch can be inferred.
  always_comb begin
    mix_d = '0;
    for (int c = 0; c < 4; c++) begin
      mix_d[32*c +: 32] = mix_col(mixIn[32*c +: 32], inverse);
    end
  end

  // NOTE: non-blocking assignment for registered state so every flop samples
  // its input on the same edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mixOut = mix_q;

endmodule

// File: tb/tb_mix_columns_all.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_all
//   Self-checking bench for mix_columns_all. The reference model multiplies
//   each column by the AES (or inverse AES) circulant matrix using a generic
//   shift-and-add GF(2^8) multiplier. A tracker holds the expected registered
//   output; a compare process checks it on every falling edge. Literal FIPS-197
//   vectors pin both the model and the DUT.
// ---------------------------------------------------------------------------
module tb_mix_columns_all;

  logic         clk;
  logic         reset;
  logic [127:0] mixIn;
  logic         inverse;
  logic [127:0] mixOut;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_q;
  logic         chk_en = 1'b0;

  mix_columns_all dut (
    .clk     (clk),
    .reset   (reset),
    .mixIn   (mixIn),
    .inverse (inverse),
    .mixOut  (mixOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply, modulus 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [8:0] t;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      t = {a, 1'b0};
      if (t[8]) t = t ^ 9'h11b;
      a = t[7:0];
    end
    return p;
  endfunction

  // Matrix-form reference: b[r] = sum_k coef[(k - r) mod 4] * a[k].
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] res = '0;
    if (inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - r + 4) % 4], a[k]);
        res[127 - 8*(4*c + r) -: 8] = b;
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected registered output, following the one-cycle latency and the
  // asynchronous clear.
  always @(posedge clk or posedge reset) begin
    if (reset) exp_q = '0;
    else       exp_q = model(mixIn, inverse);
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) check("cycle", mixOut, exp_q);
  end

  // Drive one state and return just after the capturing edge.
  task automatic apply(input logic [127:0] s, input logic inv);
    mixIn   = s;
    inverse = inv;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] q_in  [$];
    logic [127:0] x, y;
    logic         m;

    // Pin the model against FIPS-197 column vectors.
    check("model_fwd_fips",
          model(128'h6353e08c0960e104cd70b751bacad0e7, 1'b0),
          128'h5f72641557f5bc92f7be3b291db9f91a);
    check("model_fwd_cols",
          model(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0),
          128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    check("model_inv_cols",
          model(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1),
          128'hdb135345_f20a225c_d4d4d4d5_2d26314c);

    // 1. Reset and first capture.
    reset   = 1'b1;
    inverse = 1'b0;
    mixIn   = 128'h6353e08c0960e104cd70b751bacad0e7;
    #1;
    check("reset_async", mixOut, 128'h0);
    @(posedge clk); #1;
    check("reset_hold1", mixOut, 128'h0);
    @(posedge clk); #1;
    check("reset_hold2", mixOut, 128'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_capture", mixOut, 128'h5f72641557f5bc92f7be3b291db9f91a);
    chk_en = 1'b1;

    // 2. Forward column vectors.
    apply(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    check("fwd_vec1", mixOut, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    apply(128'hd4d4d4d5_2d26314c_d4bf5d30_00000000, 1'b0);
    check("fwd_vec2", mixOut, 128'hd5d5d7d6_4d7ebdf8_046681e5_00000000);

    // 3. Inverse column vectors.
    apply(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1);
    check("inv_vec1", mixOut, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);

    // Fixed points in both modes.
    apply(128'h0, 1'b0);
    check("zero_fwd", mixOut, 128'h0);
    apply(128'h0, 1'b1);
    check("zero_inv", mixOut, 128'h0);
    apply({128{1'b1}}, 1'b0);
    check("ones_fwd", mixOut, {128{1'b1}});
    apply({128{1'b1}}, 1'b1);
    check("ones_inv", mixOut, {128{1'b1}});

    // 4. Back-to-back stream of five states, no bubbles.
    for (int i = 0; i < 5; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      q_in.push_back(x);
      apply(x, 1'b0);
      check("stream_order", mixOut, model(q_in.pop_front(), 1'b0));
    end

    // 5a. Mode toggled together with data.
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(1, 0));
      apply(x, m);
      check("mode_switch", mixOut, model(x, m));
    end

    // 5b. Round trip: forward then inverse returns the original state.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      apply(x, 1'b0);
      y = mixOut;
      apply(y, 1'b1);
      check("round_trip", mixOut, x);
    end

    // 6. Reset asserted between edges while streaming.
    apply(128'h0123456789abcdeffedcba9876543210, 1'b0);
    mixIn = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    #2;
    reset = 1'b1;
    #1;
    check("reset_midstream", mixOut, 128'h0);
    @(posedge clk); #1;
    check("reset_mid_hold", mixOut, 128'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    apply(128'hd4d4d4d5_2d26314c_d4bf5d30_00000000, 1'b0);
    check("resume_fwd", mixOut, 128'hd5d5d7d6_4d7ebdf8_046681e5_00000000);
    apply(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1);
    check("resume_inv", mixOut, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
    for (int i = 0; i < 20; i++) begin
      apply({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1, 0)));
    end

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
